// File: rtl/mpu_store_unit.sv
// MPU store unit: reads one matrix register from the register file as a single snapshot,
// then streams the active m x n top-left submatrix out row-major, one element per handshake.
//
// state         | meaning
// STORE_IDLE    | ready for a command; rejects commands whose m/n are out of range
// STORE_REQUEST | holding reg_rd_en until the register file grants the read
// STORE_MATRIX  | streaming snapshot elements over valid/ready
module mpu_store_unit #(
    parameter int FP               = 32,
    parameter int M                = 3,
    parameter int N                = 3,
    parameter int MATRIX_REGISTERS = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                store_req,
    input  logic [$clog2(MATRIX_REGISTERS)-1:0] store_addr,
    input  logic [$clog2(M)-1:0]                store_m,
    input  logic [$clog2(N)-1:0]                store_n,
    output logic                                store_ready,
    output logic                                store_error,
    output logic                                store_done,
    output logic                                reg_rd_en,
    output logic [$clog2(MATRIX_REGISTERS)-1:0] reg_rd_addr,
    input  logic                                reg_rd_grant,
    input  logic [M*N*FP-1:0]                   reg_rd_data,
    output logic                                stream_valid,
    input  logic                                stream_ready,
    output logic [FP-1:0]                       stream_data,
    output logic [$clog2(M)-1:0]                stream_row,
    output logic [$clog2(N)-1:0]                stream_col,
    output logic                                stream_last
);

    localparam int AW = $clog2(MATRIX_REGISTERS);
    localparam int MW = $clog2(M);
    localparam int NW = $clog2(N);
    localparam int E  = M * N;
    localparam int IW = $clog2(E);

    typedef enum logic [1:0] {
        STORE_IDLE    = 2'd0,
        STORE_REQUEST = 2'd1,
        STORE_MATRIX  = 2'd2
    } store_state_e;

    store_state_e  r_state;
    logic [AW-1:0] r_addr;
    logic [MW-1:0] r_m;
    logic [NW-1:0] r_n;
    logic [MW-1:0] r_row;
    logic [NW-1:0] r_col;
    logic          r_ready;
    logic          r_error;
    logic          r_done;
    logic          r_rd_en;
    logic          r_valid;
    logic          r_last;
    logic [FP-1:0] r_snap [E];

    logic          w_dims_ok;
    logic          w_col_end;
    logic [MW-1:0] w_next_row;
    logic [NW-1:0] w_next_col;
    logic [IW-1:0] w_idx;

    assign w_dims_ok = (store_m != '0) && (int'(store_m) <= M) &&
                       (store_n != '0) && (int'(store_n) <= N);

    assign w_col_end  = (r_col == r_n - NW'(1));
    assign w_next_row = w_col_end ? r_row + MW'(1) : r_row;
    assign w_next_col = w_col_end ? '0 : r_col + NW'(1);

    // Stride is always N: the streamed region is the top-left corner of the full register.
    assign w_idx = IW'(r_row) * IW'(N) + IW'(r_col);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= STORE_IDLE;
            r_addr  <= '0;
            r_m     <= '0;
            r_n     <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_ready <= 1'b1;
            r_error <= 1'b0;
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_error <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                STORE_IDLE: begin
                    if (store_req) begin
                        if (w_dims_ok) begin
                            r_addr  <= store_addr;
                            r_m     <= store_m;
                            r_n     <= store_n;
                            r_ready <= 1'b0;
                            r_rd_en <= 1'b1;
                            r_state <= STORE_REQUEST;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                STORE_REQUEST: begin
                    if (reg_rd_grant) begin
                        r_rd_en <= 1'b0;
                        r_valid <= 1'b1;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_last  <= (r_m == MW'(1)) && (r_n == NW'(1));
                        r_state <= STORE_MATRIX;
                    end
                end
                STORE_MATRIX: begin
                    if (stream_ready) begin
                        if (r_last) begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_row   <= '0;
                            r_col   <= '0;
                            r_done  <= 1'b1;
                            r_ready <= 1'b1;
                            r_state <= STORE_IDLE;
                        end else begin
                            r_row  <= w_next_row;
                            r_col  <= w_next_col;
                            r_last <= (w_next_row == r_m - MW'(1)) &&
                                      (w_next_col == r_n - NW'(1));
                        end
                    end
                end
                default: begin
                    r_state <= STORE_IDLE;
                end
            endcase
        end
    end

    // Snapshot has no reset; it is only observable while streaming.
    always_ff @(posedge clk) begin
        if (r_state == STORE_REQUEST && reg_rd_grant) begin
            for (int k = 0; k < E; k++) begin
                r_snap[k] <= reg_rd_data[(E-1-k)*FP +: FP];
            end
        end
    end

    assign store_ready  = r_ready;
    assign store_error  = r_error;
    assign store_done   = r_done;
    assign reg_rd_en    = r_rd_en;
    assign reg_rd_addr  = r_addr;
    assign stream_valid = r_valid;
    assign stream_data  = r_valid ? r_snap[w_idx] : '0;
    assign stream_row   = r_row;
    assign stream_col   = r_col;
    assign stream_last  = r_last;

endmodule

// File: tb/tb_mpu_store_unit.sv
// Directed bench for mpu_store_unit: register-file side and downstream side are driven
// from tasks; expected beats come from a constant table of 1.0..9.0.
module tb_mpu_store_unit;

    logic          clk;
    logic          rst;
    logic          store_req;
    logic [2:0]    store_addr;
    logic [1:0]    store_m;
    logic [1:0]    store_n;
    logic          store_ready;
    logic          store_error;
    logic          store_done;
    logic          reg_rd_en;
    logic [2:0]    reg_rd_addr;
    logic          reg_rd_grant;
    logic [287:0]  reg_rd_data;
    logic          stream_valid;
    logic          stream_ready;
    logic [31:0]   stream_data;
    logic [1:0]    stream_row;
    logic [1:0]    stream_col;
    logic          stream_last;

    int n_cmp;
    int n_bad;

    logic [31:0]  vals [9];
    logic [287:0] image;

    mpu_store_unit #(.FP(32), .M(3), .N(3), .MATRIX_REGISTERS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .store_req    (store_req),
        .store_addr   (store_addr),
        .store_m      (store_m),
        .store_n      (store_n),
        .store_ready  (store_ready),
        .store_error  (store_error),
        .store_done   (store_done),
        .reg_rd_en    (reg_rd_en),
        .reg_rd_addr  (reg_rd_addr),
        .reg_rd_grant (reg_rd_grant),
        .reg_rd_data  (reg_rd_data),
        .stream_valid (stream_valid),
        .stream_ready (stream_ready),
        .stream_data  (stream_data),
        .stream_row   (stream_row),
        .stream_col   (stream_col),
        .stream_last  (stream_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete store; abort_after > 0 returns once that many beats have been accepted.
    task automatic do_store(input logic [2:0] addr, input int m, input int n,
                            input int gdelay, input bit toggle, input bit clobber,
                            input int abort_after);
        int beat;
        int cycles;
        int p;
        int r;
        int c;
        reg_rd_data  = image;
        stream_ready = 1'b0;
        store_req    = 1'b1;
        store_addr   = addr;
        store_m      = 2'(m);
        store_n      = 2'(n);
        step();
        store_req = 1'b0;
        chk("req_rd_en", 32'(reg_rd_en), 32'd1);
        chk("req_ready", 32'(store_ready), 32'd0);
        chk("req_addr", 32'(reg_rd_addr), 32'(addr));
        for (int i = 0; i < gdelay; i++) begin
            step();
            chk("wait_rd_en", 32'(reg_rd_en), 32'd1);
            chk("wait_valid", 32'(stream_valid), 32'd0);
        end
        reg_rd_grant = 1'b1;
        step();
        reg_rd_grant = 1'b0;
        if (clobber) reg_rd_data = {9{32'hbf800000}};
        chk("post_grant_rd_en", 32'(reg_rd_en), 32'd0);
        beat   = 0;
        cycles = 0;
        p      = 0;
        while (beat < m * n && cycles < 200) begin
            if (abort_after > 0 && beat == abort_after) return;
            stream_ready = toggle ? (p % 3 == 0) : 1'b1;
            p++;
            r = beat / n;
            c = beat % n;
            chk("beat_valid", 32'(stream_valid), 32'd1);
            chk("beat_data", stream_data, vals[r * 3 + c]);
            chk("beat_row", 32'(stream_row), 32'(r));
            chk("beat_col", 32'(stream_col), 32'(c));
            chk("beat_last", 32'(stream_last), 32'(beat == m * n - 1));
            chk("beat_no_done", 32'(store_done), 32'd0);
            if (stream_ready) beat++;
            step();
            cycles++;
        end
        chk("beat_count", 32'(beat), 32'(m * n));
        stream_ready = 1'b0;
        chk("done_pulse", 32'(store_done), 32'd1);
        chk("done_valid", 32'(stream_valid), 32'd0);
        chk("done_ready", 32'(store_ready), 32'd1);
        step();
        chk("done_clear", 32'(store_done), 32'd0);
    endtask

    task automatic bad_dims(input int m, input int n);
        store_req = 1'b1;
        store_m   = 2'(m);
        store_n   = 2'(n);
        step();
        store_req = 1'b0;
        chk("err_pulse", 32'(store_error), 32'd1);
        chk("err_ready", 32'(store_ready), 32'd1);
        chk("err_rd_en", 32'(reg_rd_en), 32'd0);
        step();
        chk("err_clear", 32'(store_error), 32'd0);
        chk("err_rd_en2", 32'(reg_rd_en), 32'd0);
        chk("err_ready2", 32'(store_ready), 32'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        vals[0] = 32'h3f800000; vals[1] = 32'h40000000; vals[2] = 32'h40400000;
        vals[3] = 32'h40800000; vals[4] = 32'h40a00000; vals[5] = 32'h40c00000;
        vals[6] = 32'h40e00000; vals[7] = 32'h41000000; vals[8] = 32'h41100000;
        for (int k = 0; k < 9; k++) image[(8-k)*32 +: 32] = vals[k];
        rst          = 1'b0;
        store_req    = 1'b0;
        store_addr   = '0;
        store_m      = '0;
        store_n      = '0;
        reg_rd_grant = 1'b0;
        reg_rd_data  = image;
        stream_ready = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(store_ready), 32'd1);
        chk("rst_valid", 32'(stream_valid), 32'd0);
        chk("rst_rd_en", 32'(reg_rd_en), 32'd0);
        chk("rst_done", 32'(store_done), 32'd0);
        chk("rst_error", 32'(store_error), 32'd0);
        chk("rst_row", 32'(stream_row), 32'd0);
        rst = 1'b1;
        step();

        do_store(3'd2, 3, 3, 1, 1'b0, 1'b0, 0);
        do_store(3'd5, 3, 3, 1, 1'b1, 1'b0, 0);
        do_store(3'd1, 2, 2, 1, 1'b0, 1'b0, 0);
        bad_dims(0, 3);
        bad_dims(3, 0);
        do_store(3'd7, 3, 3, 5, 1'b0, 1'b1, 0);
        do_store(3'd2, 1, 3, 0, 1'b0, 1'b0, 0);

        do_store(3'd3, 3, 3, 1, 1'b0, 1'b0, 4);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(stream_valid), 32'd0);
        chk("arst_ready", 32'(store_ready), 32'd1);
        chk("arst_done", 32'(store_done), 32'd0);
        stream_ready = 1'b0;
        step();
        chk("arst_no_done", 32'(store_done), 32'd0);
        rst = 1'b1;
        step();
        chk("arst_idle_done", 32'(store_done), 32'd0);
        do_store(3'd3, 3, 3, 1, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mpu_store_unit.md
Name: mpu_store_unit

Overview:
- Read-side counterpart of the MPU load path.
- On an MPU_STORE request, arbitrates for one matrix register, snapshots its contents, then streams the active m×n elements out one float_sp per beat over a valid/ready handshake.
- Sits between the matrix register file and the MPU output bus.
- State machine uses store_state_e: STORE_IDLE, STORE_REQUEST, STORE_MATRIX.

Parameters:
- FP, 32, floating-point word width.
- M, 3, maximum register rows.
- N, 3, maximum register columns.
- MATRIX_REGISTERS, 8, register file depth.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, asynchronous, active-low.
- store_req  in  1  store command; sampled only in STORE_IDLE.
- store_addr  in  $clog2(MATRIX_REGISTERS)  source register address.
- store_m  in  $clog2(M)  rows to store, valid range 1..M.
- store_n  in  $clog2(N)  columns to store, valid range 1..N.
- store_ready  out  1  unit idle and accepting commands.
- store_error  out  1  one-cycle pulse: command rejected for invalid dimensions.
- store_done  out  1  one-cycle pulse: last element transferred.
- reg_rd_en  out  1  read request to register file.
- reg_rd_addr  out  $clog2(MATRIX_REGISTERS)  latched source address.
- reg_rd_grant  in  1  register file grants read; data valid this cycle.
- reg_rd_data  in  M*N*FP  full register, row-major, element [0][0] in the MSBs.
- stream_valid  out  1  output element valid.
- stream_ready  in  1  downstream accepts element.
- stream_data  out  FP  element value (float_sp).
- stream_row  out  $clog2(M)  row index of current element.
- stream_col  out  $clog2(N)  column index of current element.
- stream_last  out  1  current element is the final one.

Behaviour:
- Reset (asserted, async): state=STORE_IDLE; store_ready=1; all other outputs 0; row/col counters 0. Release is synchronous to clk.
- STORE_IDLE:
  - store_ready=1.
  - store_req with m∈1..M and n∈1..N: latch addr/m/n, go to STORE_REQUEST next cycle.
  - store_req with m or n out of range: store_error=1 for exactly one cycle, stay in STORE_IDLE, no reg_rd_en.
- STORE_REQUEST:
  - store_ready=0; reg_rd_en=1; reg_rd_addr=latched addr.
  - Wait indefinitely for reg_rd_grant.
  - In the grant cycle, capture reg_rd_data into an internal M*N*FP snapshot and go to STORE_MATRIX with row=col=0.
  - reg_rd_en=0 from the next cycle onward; the register file is free during streaming.
- STORE_MATRIX:
  - stream_valid=1; stream_data=snapshot[row*N+col]. The stride is always N: the stored region is the top-left m×n submatrix.
  - stream_data/row/col/last are held stable while valid && !ready.
  - On valid && ready:
    - col==n-1: col=0, row++.
    - otherwise: col++.
  - stream_last=1 when row==m-1 && col==n-1.
  - Handshake on the last element: next cycle state=STORE_IDLE, stream_valid=0, store_done=1 for one cycle, store_ready=1. A store_req in that same cycle is accepted.
- Latency: req cycle t → STORE_REQUEST at t+1; grant at cycle g → first stream_valid at g+1. With ready held at 1, one element per cycle.
- store_req outside STORE_IDLE is ignored; no queuing, no error.
- Reset mid-operation returns to STORE_IDLE immediately. The partial transfer is abandoned; no done/error pulse.
- Snapshot is not cleared by reset; it is never visible outside STORE_MATRIX.

Test Plan:
- Register 2 holds 1.0..9.0 (0x3f800000, 0x40000000 … 0x41100000); store 3×3; grant 1 cycle after reg_rd_en; ready=1 → 9 consecutive beats in row-major order, stream_last only on beat 9 (0x41100000, row 2, col 2), store_done the following cycle, reg_rd_addr=2.
- Same 3×3 data; stream_ready toggled 1,0,0,1,… → every element delivered exactly once in order; stream_data and row/col stable during stalls.
- Store 2×2 from the 3×3 register → beats 0x3f800000, 0x40000000, 0x40800000, 0x40a00000 (1.0, 2.0, 4.0, 5.0); last on beat 4.
- store_m=0, then store_n=0 → store_error pulses 1 cycle each; reg_rd_en never asserted; store_ready stays 1.
- Grant delayed 5 cycles; reg_rd_data overwritten with 0xbf800000 the cycle after grant → streamed values are the pre-overwrite values; reg_rd_en high exactly through the grant cycle.
- rst asserted asynchronously after 4 beats of a 3×3 store → stream_valid=0 and store_ready=1 immediately, no done pulse; a new 3×3 store then starts at element [0][0].
